// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit common-anode 7-segment scanner for an HH:MM display.
// Double-buffers the BCD time word so a frame never tears, blanks all anodes
// for a guard interval at the start of every digit slot, and optionally blinks
// the colon (digit-2 decimal point) when COLON_BLINK_EN is defined.
module seven_seg_scan #(
   parameter int TICKS_PER_DIGIT = 50000,
   parameter int GUARD_TICKS     = 500,
   parameter int LZ_BLANK        = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bcd_in,
   input  logic        upd,
   input  logic        sec_pulse,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int PW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   pend_q, pend_d;
   logic          pvld_q, pvld_d;
   logic [15:0]   disp_q, disp_d;
   logic          colon_q, colon_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          fd_q, fd_d;

   logic          tick, boundary, blank;
   logic [3:0]    nib;

   // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
   function automatic logic [6:0] bcd2seg(input logic [3:0] n);
      case (n)
         4'd0:    bcd2seg = 7'h40;
         4'd1:    bcd2seg = 7'h79;
         4'd2:    bcd2seg = 7'h24;
         4'd3:    bcd2seg = 7'h30;
         4'd4:    bcd2seg = 7'h19;
         4'd5:    bcd2seg = 7'h12;
         4'd6:    bcd2seg = 7'h02;
         4'd7:    bcd2seg = 7'h78;
         4'd8:    bcd2seg = 7'h00;
         4'd9:    bcd2seg = 7'h10;
         default: bcd2seg = 7'h3F;
      endcase
   endfunction

   assign tick     = (presc_q == PW'(TICKS_PER_DIGIT - 1));
   assign boundary = tick && (idx_q == 2'd3);

   // Scan timing and double-buffer next state; disp only moves at a frame boundary.
   always_comb begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = tick ? idx_q + 2'd1 : idx_q;
      pend_d  = pend_q;
      pvld_d  = pvld_q;
      disp_d  = disp_q;
      if (upd) begin
         pend_d = bcd_in;
         pvld_d = 1'b1;
      end
      if (boundary) begin
         // An update landing on the boundary itself bypasses the pending slot.
         if (upd) begin
            disp_d = bcd_in;
            pvld_d = 1'b0;
         end else if (pvld_q) begin
            disp_d = pend_q;
            pvld_d = 1'b0;
         end
      end
   end

`ifdef COLON_BLINK_EN
   // Colon toggles once per second, giving a 0.5 Hz 50% blink.
   always_comb colon_d = sec_pulse ? ~colon_q : colon_q;
`else
   logic unused_sec_pulse;
   assign unused_sec_pulse = sec_pulse;
   // Colon permanently lit.
   always_comb colon_d = 1'b1;
`endif

   // Pin drive for the current slot, registered one cycle later.
   always_comb begin
      nib   = disp_q[{idx_q, 2'b00} +: 4];
      blank = (presc_q < PW'(GUARD_TICKS)) ||
              ((LZ_BLANK != 0) && (idx_q == 2'd3) && (disp_q[15:12] == 4'd0));
      an_d  = blank ? 4'hF : ~(4'b0001 << idx_q);
      seg_d = blank ? 7'h7F : bcd2seg(nib);
      dp_d  = (!blank && (idx_q == 2'd2)) ? ~colon_q : 1'b1;
      fd_d  = boundary;
   end

   // State and output registers; reset drops the display dark immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         idx_q   <= 2'd0;
         pend_q  <= 16'h0000;
         pvld_q  <= 1'b0;
         disp_q  <= 16'h0000;
         colon_q <= 1'b1;
         an_q    <= 4'hF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         fd_q    <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         pvld_q  <= pvld_d;
         disp_q  <= disp_d;
         colon_q <= colon_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         fd_q    <= fd_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with 4 cycles per digit and a 1-cycle guard.
// Each frame task pushes the expected active-anode cycles into a queue; a
// negedge monitor pops and compares whenever an anode is driven.
module tb_seven_seg_scan;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] bcd_in;
   logic        upd;
   logic        sec_pulse;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 1'b0;
   logic exp_colon = 1'b1;
   exp_t sb[$];
   exp_t got;

   seven_seg_scan #(
      .TICKS_PER_DIGIT(4),
      .GUARD_TICKS    (1),
      .LZ_BLANK       (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bcd_in    (bcd_in),
      .upd       (upd),
      .sec_pulse (sec_pulse),
      .an        (an),
      .seg       (seg),
      .dp        (dp),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'd0: seg_of = 7'h40;  4'd1: seg_of = 7'h79;
         4'd2: seg_of = 7'h24;  4'd3: seg_of = 7'h30;
         4'd4: seg_of = 7'h19;  4'd5: seg_of = 7'h12;
         4'd6: seg_of = 7'h02;  4'd7: seg_of = 7'h78;
         4'd8: seg_of = 7'h00;  4'd9: seg_of = 7'h10;
         default: seg_of = 7'h3F;
      endcase
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every driven-anode cycle must match the next expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         total++;
         if (an !== 4'hF) begin
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_extra: an=%b seg=%h dp=%b with nothing expected", an, seg, dp);
            end else begin
               got = sb.pop_front();
               if ({an, seg, dp} !== got) begin
                  bad++;
                  $display("FAIL sb_digit: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                           an, seg, dp, got.an, got.seg, got.dp);
               end
            end
         end else if (seg !== 7'h7F || dp !== 1'b1) begin
            bad++;
            $display("FAIL sb_dark: got seg=%h dp=%b expected seg=7f dp=1", seg, dp);
         end
      end
   end

   // One 16-cycle frame starting at the negedge where the scan is at idx 0,
   // prescaler 0. d is the word expected on the display for this frame.
   task automatic run_frame(input logic [15:0] d,
                            input int a1, input logic [15:0] v1,
                            input int a2, input logic [15:0] v2,
                            input bit sp);
      exp_t e;
`ifdef COLON_BLINK_EN
      if (sp) exp_colon = ~exp_colon;
`endif
      for (int i = 0; i < 4; i++) begin
         if (!(i == 3 && d[15:12] == 4'd0)) begin
            e.an  = ~(4'b0001 << i);
            e.seg = seg_of(d[i*4 +: 4]);
            e.dp  = (i == 2) ? ~exp_colon : 1'b1;
            repeat (3) sb.push_back(e);
         end
      end
      for (int c = 0; c < 16; c++) begin
         upd       = (c == a1) || (c == a2);
         bcd_in    = (c == a2) ? v2 : v1;
         sec_pulse = sp && (c == 0);
         @(negedge clk);
         upd       = 1'b0;
         sec_pulse = 1'b0;
         if (c == 0) chk("guard_an", {12'h0, an}, 16'h000F);
         if (c == 1) chk("first_an", {12'h0, an}, 16'h000E);
         chk("frame_done", {15'h0, frame_done}, {15'h0, (c == 15)});
      end
   endtask

   initial begin
      rst = 1'b1; upd = 1'b0; bcd_in = 16'h0; sec_pulse = 1'b0;
      #1;
      chk("rst_an",  {12'h0, an},  16'h000F);
      chk("rst_seg", {9'h0, seg},  16'h007F);
      chk("rst_dp",  {15'h0, dp},  16'h0001);
      chk("rst_fd",  {15'h0, frame_done}, 16'h0000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_midscan_an", {12'h0, an}, 16'h000D);
      // Asynchronous reset away from any clock edge.
      #2 rst = 1'b1;
      #1;
      chk("async_an",  {12'h0, an},  16'h000F);
      chk("async_seg", {9'h0, seg},  16'h007F);
      chk("async_dp",  {15'h0, dp},  16'h0001);
      chk("async_fd",  {15'h0, frame_done}, 16'h0000);
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      rst    = 1'b0;
      // Blank display, 1234 loaded mid-frame, shown from the next frame.
      run_frame(16'h0000,  6, 16'h1234, -1, 16'h0, 1'b0);
      run_frame(16'h1234, -1, 16'h0,    -1, 16'h0, 1'b0);
      // Two updates mid-frame: current frame untouched, last one wins.
      run_frame(16'h1234,  5, 16'h0945,  7, 16'h0959, 1'b0);
      // Update on the boundary cycle goes straight to the display.
      run_frame(16'h0959, 15, 16'h2359, -1, 16'h0, 1'b0);
      run_frame(16'h2359,  3, 16'hA1F0, -1, 16'h0, 1'b0);
      // Non-BCD nibbles show dashes; leading digit A is not blanked.
      run_frame(16'hA1F0, -1, 16'h0,    -1, 16'h0, 1'b0);
      // Colon behaviour across three second strobes.
      run_frame(16'hA1F0, -1, 16'h0,    -1, 16'h0, 1'b1);
      run_frame(16'hA1F0, -1, 16'h0,    -1, 16'h0, 1'b1);
      run_frame(16'hA1F0, -1, 16'h0,    -1, 16'h0, 1'b1);
      @(negedge clk);
      chk("sb_drained", 16'(sb.size()), 16'h0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
